// File: rtl/decim_sched_pkg.sv
// Shared types and defaults for the decimation-chain scheduler.
// The FSM state enum, default sizing constants and the stage-index
// width helper live here so the arbiter and the top agree on widths.
package decim_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RETIRE
   } sched_state_t;

   localparam int DEF_NUM_STAGES  = 4;
   localparam int DEF_DECIM       = 4;
   localparam int DEF_DATA_W      = 8;
   localparam int DEF_ENG_TIMEOUT = 64;

   // Width of an index into n items, never narrower than one bit
   function automatic int stage_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/decim_sched_arb.sv
// Highest-index-first priority encoder over the per-stage pending flags.
// Favouring the deepest stage drains the chain before admitting new
// input, which keeps the shallow slots from backing up behind it.
module decim_sched_arb
   import decim_sched_pkg::*;
#(
   parameter  int NUM_STAGES = DEF_NUM_STAGES,
   localparam int SW         = stage_idx_w(NUM_STAGES)
) (
   input  logic [NUM_STAGES-1:0] pend_v,
   output logic [SW-1:0]         grant,
   output logic                  any_valid
);

   // Ascending scan so the last (highest) valid index wins
   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (pend_v[i]) begin
            grant     = SW'(i);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/decim_chain_scheduler.sv
// Time-multiplexes one shared FIR/decimate MAC engine across a cascade of
// decimation stages. Each stage owns a one-entry pending slot and a
// decimation phase; the FSM grants the engine one job at a time and routes
// compute results to the next stage's slot or to the audio output.
// Optional feature macro: SCHED_OVERRUN_CNT_EN adds per-stage 8-bit
// saturating drop counters on the overrun_cnt port.
module decim_chain_scheduler
   import decim_sched_pkg::*;
#(
   parameter  int NUM_STAGES  = DEF_NUM_STAGES,
   parameter  int DECIM       = DEF_DECIM,
   parameter  int DATA_W      = DEF_DATA_W,
   parameter  int ENG_TIMEOUT = DEF_ENG_TIMEOUT,
   localparam int SW          = stage_idx_w(NUM_STAGES)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     eng_start,
   output logic [SW-1:0]            eng_stage,
   output logic signed [DATA_W-1:0] eng_sample,
   output logic                     eng_compute,
   input  logic                     eng_done,
   input  logic signed [DATA_W-1:0] eng_result,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   output logic [NUM_STAGES-1:0]    overrun,
   output logic                     timeout_err,
   input  logic                     clr_err,
   output logic                     busy
`ifdef SCHED_OVERRUN_CNT_EN
   ,
   output logic [NUM_STAGES*8-1:0]  overrun_cnt
`endif
);

   localparam int PW   = stage_idx_w(DECIM);
   localparam int TW   = $clog2(ENG_TIMEOUT + 1);
   localparam int LAST = NUM_STAGES - 1;

   sched_state_t              state;
   logic [NUM_STAGES-1:0]     pend_v;
   logic signed [DATA_W-1:0]  pend_d [NUM_STAGES];
   logic [PW-1:0]             phase  [NUM_STAGES];
   logic [TW-1:0]             tmr;
   logic signed [DATA_W-1:0]  res_q;

   logic [SW-1:0]             grant;
   logic                      any_valid;
   logic                      grant_go;
   logic                      retire_fill;
   logic                      timeout_hit;
   logic signed [DATA_W-1:0]  sel_d;
   logic                      sel_comp;
   logic [NUM_STAGES-1:0]     take;
   logic [NUM_STAGES-1:0]     fill_v;
   logic [NUM_STAGES-1:0]     drop;
   logic signed [DATA_W-1:0]  fill_d [NUM_STAGES];

   decim_sched_arb #(
      .NUM_STAGES (NUM_STAGES)
   ) u_arb (
      .pend_v    (pend_v),
      .grant     (grant),
      .any_valid (any_valid)
   );

   assign busy = (state != S_IDLE);

   // Grant selection, slot fill/consume decode and drop detection
   always_comb begin
      grant_go    = (state == S_IDLE) && en && any_valid;
      retire_fill = (state == S_RETIRE) && eng_compute && (eng_stage != SW'(LAST));
      timeout_hit = (state == S_WAIT) && !eng_done && (tmr >= TW'(ENG_TIMEOUT - 1));
      sel_d       = '0;
      sel_comp    = 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) begin
         take[s]   = grant_go && (grant == SW'(s));
         fill_v[s] = 1'b0;
         fill_d[s] = '0;
         if (grant == SW'(s)) begin
            sel_d    = pend_d[s];
            sel_comp = (phase[s] == PW'(DECIM - 1));
         end
      end
      fill_v[0] = in_valid;
      fill_d[0] = in_data;
      for (int s = 1; s < NUM_STAGES; s++) begin
         if (retire_fill && (eng_stage == SW'(s - 1))) begin
            fill_v[s] = 1'b1;
            fill_d[s] = res_q;
         end
      end
      drop = fill_v & pend_v & ~take;
   end

   // Pending slots: a fill wins if the slot is empty or consumed this cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_v <= '0;
         for (int s = 0; s < NUM_STAGES; s++) pend_d[s] <= '0;
      end else begin
         for (int s = 0; s < NUM_STAGES; s++) begin
            if (fill_v[s] && (!pend_v[s] || take[s])) begin
               pend_v[s] <= 1'b1;
               pend_d[s] <= fill_d[s];
            end else if (take[s]) begin
               pend_v[s] <= 1'b0;
            end
         end
      end
   end

   // Decimation phase advances only when a job retires normally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_STAGES; s++) phase[s] <= '0;
      end else begin
         for (int s = 0; s < NUM_STAGES; s++) begin
            if ((state == S_RETIRE) && (eng_stage == SW'(s))) begin
               phase[s] <= (phase[s] == PW'(DECIM - 1)) ? '0 : phase[s] + 1'b1;
            end
         end
      end
   end

   // Job FSM: grant, launch, wait with timeout, retire; outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         eng_start   <= 1'b0;
         eng_stage   <= '0;
         eng_sample  <= '0;
         eng_compute <= 1'b0;
         tmr         <= '0;
         res_q       <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         timeout_err <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_go) begin
                  eng_stage   <= grant;
                  eng_sample  <= sel_d;
                  eng_compute <= sel_comp;
                  eng_start   <= 1'b1;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               tmr   <= TW'(1);
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (eng_done) begin
                  res_q <= eng_result;
                  state <= S_RETIRE;
                  if (eng_compute && (eng_stage == SW'(LAST))) begin
                     out_valid <= 1'b1;
                     out_data  <= eng_result;
                  end
               end else if (timeout_hit) begin
                  state <= S_IDLE;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            S_RETIRE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
         if (clr_err) timeout_err <= 1'b0;
         else if (timeout_hit) timeout_err <= 1'b1;
      end
   end

   // Sticky per-stage drop flags; a clear beats a same-cycle drop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overrun <= '0;
      else if (clr_err) overrun <= '0;
      else overrun <= overrun | drop;
   end

`ifdef SCHED_OVERRUN_CNT_EN
   // Per-stage saturating drop counters, stage 0 in the low byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_cnt <= '0;
      end else if (clr_err) begin
         overrun_cnt <= '0;
      end else begin
         for (int s = 0; s < NUM_STAGES; s++) begin
            if (drop[s] && (overrun_cnt[s*8 +: 8] != 8'hFF)) begin
               overrun_cnt[s*8 +: 8] <= overrun_cnt[s*8 +: 8] + 8'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_decim_chain_scheduler.sv
// Directed bench for decim_chain_scheduler with a 2-stage chain and a
// model engine (configurable latency, result = sample + 1, optional hang).
// Build with SCHED_OVERRUN_CNT_EN to also exercise the drop counters.
module tb_decim_chain_scheduler;

   localparam int NS   = 2;
   localparam int DEC  = 4;
   localparam int DW   = 8;
   localparam int TOUT = 64;

   logic                 clk;
   logic                 rst_n;
   logic                 en;
   logic                 in_valid;
   logic signed [DW-1:0] in_data;
   logic                 eng_start;
   logic [0:0]           eng_stage;
   logic signed [DW-1:0] eng_sample;
   logic                 eng_compute;
   logic                 eng_done;
   logic signed [DW-1:0] eng_result;
   logic                 out_valid;
   logic signed [DW-1:0] out_data;
   logic [NS-1:0]        overrun;
   logic                 timeout_err;
   logic                 clr_err;
   logic                 busy;
`ifdef SCHED_OVERRUN_CNT_EN
   logic [NS*8-1:0]      overrun_cnt;
`endif

   int nTests  = 0;
   int nFailed = 0;
   int outCount = 0;

   int                   engLatency = 5;
   bit                   engHang = 0;
   bit                   engBusy = 0;
   int                   engCnt = 0;
   logic signed [DW-1:0] engSample = '0;

   decim_chain_scheduler #(
      .NUM_STAGES  (NS),
      .DECIM       (DEC),
      .DATA_W      (DW),
      .ENG_TIMEOUT (TOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .eng_start   (eng_start),
      .eng_stage   (eng_stage),
      .eng_sample  (eng_sample),
      .eng_compute (eng_compute),
      .eng_done    (eng_done),
      .eng_result  (eng_result),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .overrun     (overrun),
      .timeout_err (timeout_err),
      .clr_err     (clr_err),
      .busy        (busy)
`ifdef SCHED_OVERRUN_CNT_EN
      ,
      .overrun_cnt (overrun_cnt)
`endif
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model engine: launch seen mid-cycle, done pulse engLatency cycles later
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         engBusy    = 0;
         engCnt     = 0;
         eng_done   = 1'b0;
         eng_result = '0;
      end else begin
         eng_done = 1'b0;
         if (engBusy) begin
            engCnt = engCnt - 1;
            if (engCnt == 0) begin
               eng_done   = 1'b1;
               eng_result = engSample + 8'sd1;
               engBusy    = 0;
            end
         end
         if (eng_start && !engHang) begin
            engBusy   = 1;
            engCnt    = engLatency;
            engSample = eng_sample;
         end
      end
   end

   // Counts cycles with out_valid high
   always @(negedge clk) begin
      if (out_valid) outCount = outCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nTests++;
      assert (observed === expected) else begin
         nFailed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic signed [DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic waitStart(input string tag);
      bit seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         seen = eng_start;
      end
      checkOutput(tag, 32'(seen), 32'd1);
   endtask

   task automatic waitIdle(input string tag);
      int quiet = 0;
      for (int i = 0; i < 400 && quiet < 4; i++) begin
         @(negedge clk);
         quiet = busy ? 0 : quiet + 1;
      end
      checkOutput(tag, 32'(quiet >= 4), 32'd1);
   endtask

   task automatic runJob(input logic signed [DW-1:0] d, input string tag);
      applyStimulus(d);
      waitStart(tag);
      waitIdle(tag);
   endtask

   initial begin
      rst_n    = 1'b0;
      en       = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      clr_err  = 1'b0;
      #2;
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_eng_start", 32'(eng_start), 0);
      checkOutput("rst_out_valid", 32'(out_valid), 0);
      checkOutput("rst_out_data", 32'(out_data), 0);
      checkOutput("rst_overrun", 32'(overrun), 0);
      checkOutput("rst_timeout", 32'(timeout_err), 0);
      tick();
      rst_n = 1'b1;
      en    = 1'b1;
      tick();

      // 16 inputs, 32 cycles apart: one final output of 17
      outCount = 0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(8'(i));
         repeat (31) tick();
      end
      repeat (40) tick();
      checkOutput("chain_out_count", 32'(outCount), 1);
      checkOutput("chain_out_data", 32'(out_data), 17);
      checkOutput("chain_overrun", 32'(overrun), 0);
      checkOutput("chain_busy", 32'(busy), 0);

      // Single input at idle: launch exactly two cycles later
      applyStimulus(8'sd9);
      checkOutput("lat_start_early", 32'(eng_start), 0);
      tick();
      checkOutput("lat_start", 32'(eng_start), 1);
      checkOutput("lat_stage", 32'(eng_stage), 0);
      checkOutput("lat_compute", 32'(eng_compute), 0);
      checkOutput("lat_sample", 32'(eng_sample), 9);
      tick();
      checkOutput("lat_start_pulse", 32'(eng_start), 0);
      waitIdle("lat_idle");

      // Stage 0 phases 1,2 then a compute job; new input lands during it
      runJob(8'sd20, "prio_j20");
      runJob(8'sd21, "prio_j21");
      applyStimulus(8'sd30);
      waitStart("prio_start30");
      checkOutput("prio_compute30", 32'(eng_compute), 1);
      tick();
      tick();
      applyStimulus(8'sd40);
      waitStart("prio_first");
      checkOutput("prio_first_stage", 32'(eng_stage), 1);
      checkOutput("prio_first_sample", 32'(eng_sample), 31);
      checkOutput("prio_first_compute", 32'(eng_compute), 0);
      waitStart("prio_second");
      checkOutput("prio_second_stage", 32'(eng_stage), 0);
      checkOutput("prio_second_sample", 32'(eng_sample), 40);
      waitIdle("prio_idle");

      // Hung engine: abort ENG_TIMEOUT cycles after launch, then next grant
      engHang = 1;
      applyStimulus(8'sd50);
      waitStart("tout_start");
      applyStimulus(8'sd60);
      repeat (TOUT - 2) tick();
      checkOutput("tout_early_flag", 32'(timeout_err), 0);
      checkOutput("tout_early_busy", 32'(busy), 1);
      tick();
      checkOutput("tout_flag", 32'(timeout_err), 1);
      checkOutput("tout_idle", 32'(busy), 0);
      engHang = 0;
      tick();
      checkOutput("tout_next_start", 32'(eng_start), 1);
      checkOutput("tout_next_sample", 32'(eng_sample), 60);
      checkOutput("tout_next_compute", 32'(eng_compute), 0);
      waitIdle("tout_idle2");

      // Slow engine with inputs every 2 cycles: later samples dropped
      engLatency = 20;
      applyStimulus(8'sd70);
      tick();
      applyStimulus(8'sd71);
      tick();
      applyStimulus(8'sd72);
      tick();
      applyStimulus(8'sd73);
      checkOutput("ovr_flag", 32'(overrun), 1);
`ifdef SCHED_OVERRUN_CNT_EN
      checkOutput("ovr_cnt", 32'(overrun_cnt[7:0]), 2);
`endif
      waitStart("ovr_retained");
      checkOutput("ovr_retained_sample", 32'(eng_sample), 71);
      checkOutput("ovr_retained_compute", 32'(eng_compute), 1);
      checkOutput("ovr_tout_sticky", 32'(timeout_err), 1);
      engLatency = 5;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      checkOutput("clr_overrun", 32'(overrun), 0);
      checkOutput("clr_timeout", 32'(timeout_err), 0);
      waitIdle("ovr_idle");

`ifdef SCHED_OVERRUN_CNT_EN
      // Continuous input into a hung engine saturates the counter
      engHang = 1;
      for (int i = 0; i < 300; i++) applyStimulus(8'(i));
      checkOutput("cnt_saturate", 32'(overrun_cnt[7:0]), 255);
      engHang = 0;
      waitIdle("cnt_idle");
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      checkOutput("cnt_clear", 32'(overrun_cnt), 0);
`endif

      // Reset in WAIT: everything clears at once, phase restarts at 0
      runJob(8'sd80, "rst_job80");
      applyStimulus(8'sd90);
      waitStart("rst_start90");
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      checkOutput("arst_busy", 32'(busy), 0);
      checkOutput("arst_sample", 32'(eng_sample), 0);
      checkOutput("arst_out_data", 32'(out_data), 0);
      checkOutput("arst_stage", 32'(eng_stage), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(8'(100 + i));
         waitStart("post_rst_start");
         checkOutput("post_rst_compute", 32'(eng_compute), (i == 3) ? 1 : 0);
         waitIdle("post_rst_idle");
      end

      // Enable low: input is held pending, granted once enable returns
      en = 1'b0;
      applyStimulus(8'sd110);
      begin
         bit sawStart = 0;
         for (int i = 0; i < 10; i++) begin
            tick();
            if (eng_start) sawStart = 1;
         end
         checkOutput("en_low_nostart", 32'(sawStart), 0);
      end
      en = 1'b1;
      waitStart("en_high_start");
      checkOutput("en_high_sample", 32'(eng_sample), 110);
      waitIdle("en_idle");

      $display("[TB] %0d tests run, %0d failed", nTests, nFailed);
      $finish;
   end

endmodule
